fma_seq_ctrl: RTL and testbench

- Issue/completion sequencer for the fixed-latency pipelined FMA datapath and its exception-flag logic.
- Accepts one operation per cycle, tracks valid/tag through LATENCY stages, and drives the datapath stage-enable.
- Applies output backpressure and presents the final-stage flags with the result.
- Accumulates sticky IEEE flags (fflags NV/DZ/OF/UF/NX) with CSR read/write and supports pipeline flush.

---
 rtl/fma_seq_ctrl_pkg.sv | 30 +++
 rtl/fma_flag_acc.sv | 38 +++
 rtl/fma_seq_ctrl.sv | 103 ++++++++++
 tb/tb_fma_seq_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fma_seq_ctrl_pkg.sv
// Shared FPU definitions: fflags bit positions, flag vector type and default
// pipeline geometry used by the FMA sequencer and other FP units.
package fma_seq_ctrl_pkg;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam int unsigned FFLAGS_W    = 5;
    localparam int unsigned FMA_LATENCY = 3;
    localparam int unsigned FMA_TAGW    = 5;

    typedef logic [FFLAGS_W-1:0] fflags_t;

    // FMA never divides, so DZ is always clear in its flag vector.
    function automatic fflags_t pack_fma_flags(input logic nv, input logic of,
                                               input logic uf, input logic nx);
        fflags_t f;
        f          = '0;
        f[FLAG_NV] = nv;
        f[FLAG_DZ] = 1'b0;
        f[FLAG_OF] = of;
        f[FLAG_UF] = uf;
        f[FLAG_NX] = nx;
        return f;
    endfunction

endpackage

// File: rtl/fma_flag_acc.sv
// Sticky fflags register: a CSR write replaces the value, then any completing
// operation's flags are ORed on top so nothing raised in the same cycle is lost.
module fma_flag_acc
    import fma_seq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                csr_wr_en_i,
    input  logic [FFLAGS_W-1:0] csr_wr_data_i,
    input  logic                acc_en_i,
    input  logic [FFLAGS_W-1:0] acc_flags_i,
    output logic [FFLAGS_W-1:0] fflags_o
);

    fflags_t fflags_q;
    fflags_t fflags_d;

    always_comb begin
        fflags_d = fflags_q;
        if (csr_wr_en_i) begin
            fflags_d = csr_wr_data_i;
        end
        if (acc_en_i) begin
            fflags_d = fflags_d | acc_flags_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_o = fflags_q;

endmodule

// File: rtl/fma_seq_ctrl.sv
// Issue/completion sequencer for the fixed-latency FMA datapath: tracks valid
// and tag per stage, stalls the whole pipe on result backpressure, handles flush.
module fma_seq_ctrl
    import fma_seq_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = FMA_LATENCY,
    parameter int unsigned TAGW    = FMA_TAGW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                IssueValid,
    output logic                IssueReady,
    input  logic [TAGW-1:0]     IssueTag,
    input  logic                FlushE,
    output logic                StageEn,
    input  logic                FmaInvalid,
    input  logic                FmaOverflow,
    input  logic                FmaUnderflow,
    input  logic                FmaInexact,
    output logic                ResValid,
    input  logic                ResReady,
    output logic [TAGW-1:0]     ResTag,
    output logic [FFLAGS_W-1:0] ResFlags,
    input  logic                CsrWrEn,
    input  logic [FFLAGS_W-1:0] CsrWrData,
    output logic [FFLAGS_W-1:0] FFlags,
    output logic                Busy
);

    localparam int unsigned TAG_VEC_W = LATENCY * TAGW;

    // Stage 0 occupies the low bits; the final stage is the top slice.
    logic [LATENCY-1:0]   valid_q;
    logic [LATENCY-1:0]   valid_d;
    logic [TAG_VEC_W-1:0] tag_q;
    logic [TAG_VEC_W-1:0] tag_d;
    logic [LATENCY-1:0]   valid_shift;
    logic [TAG_VEC_W-1:0] tag_shift;

    logic    stall;
    logic    stage_en;
    logic    accept;
    fflags_t res_flags;

    if (LATENCY > 1) begin : g_shift
        assign valid_shift = {valid_q[LATENCY-2:0], IssueValid};
        assign tag_shift   = {tag_q[TAG_VEC_W-TAGW-1:0], IssueTag};
    end else begin : g_single
        assign valid_shift = IssueValid;
        assign tag_shift   = IssueTag;
    end

    // An unaccepted final-stage result freezes every stage; bubbles are not squeezed out.
    assign stall    = valid_q[LATENCY-1] & ~ResReady;
    assign stage_en = ~stall;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (stage_en) begin
            valid_d = valid_shift;
            tag_d   = tag_shift;
        end
        // Flush wins even over a stall and also kills the op issued this cycle.
        if (FlushE) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign res_flags = valid_q[LATENCY-1]
                     ? pack_fma_flags(FmaInvalid, FmaOverflow, FmaUnderflow, FmaInexact)
                     : fflags_t'(0);

    assign accept = valid_q[LATENCY-1] & ResReady & ~FlushE;

    fma_flag_acc u_flag_acc (
        .clk          (clk),
        .reset        (reset),
        .csr_wr_en_i  (CsrWrEn),
        .csr_wr_data_i(CsrWrData),
        .acc_en_i     (accept),
        .acc_flags_i  (res_flags),
        .fflags_o     (FFlags)
    );

    assign IssueReady = stage_en;
    assign StageEn    = stage_en;
    assign ResValid   = valid_q[LATENCY-1];
    assign ResTag     = tag_q[TAG_VEC_W-1 -: TAGW];
    assign ResFlags   = res_flags;
    assign Busy       = |valid_q;

endmodule

// File: tb/tb_fma_seq_ctrl.sv
// Directed and randomized checks of the FMA issue/completion sequencer.
module tb_fma_seq_ctrl;

    localparam int unsigned LAT = 3;
    localparam int unsigned TW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          IssueValid;
    logic          IssueReady;
    logic [TW-1:0] IssueTag;
    logic          FlushE;
    logic          StageEn;
    logic          FmaInvalid, FmaOverflow, FmaUnderflow, FmaInexact;
    logic          ResValid;
    logic          ResReady;
    logic [TW-1:0] ResTag;
    logic [4:0]    ResFlags;
    logic          CsrWrEn;
    logic [4:0]    CsrWrData;
    logic [4:0]    FFlags;
    logic          Busy;

    int errors = 0;
    int checks = 0;

    fma_seq_ctrl #(.LATENCY(LAT), .TAGW(TW)) dut (
        .clk(clk), .reset(reset),
        .IssueValid(IssueValid), .IssueReady(IssueReady), .IssueTag(IssueTag),
        .FlushE(FlushE), .StageEn(StageEn),
        .FmaInvalid(FmaInvalid), .FmaOverflow(FmaOverflow),
        .FmaUnderflow(FmaUnderflow), .FmaInexact(FmaInexact),
        .ResValid(ResValid), .ResReady(ResReady), .ResTag(ResTag), .ResFlags(ResFlags),
        .CsrWrEn(CsrWrEn), .CsrWrData(CsrWrData), .FFlags(FFlags), .Busy(Busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IssueValid = 1'b0; IssueTag = '0; FlushE = 1'b0; ResReady = 1'b1;
        FmaInvalid = 1'b0; FmaOverflow = 1'b0; FmaUnderflow = 1'b0; FmaInexact = 1'b0;
        CsrWrEn = 1'b0; CsrWrData = '0;
    endtask

    task automatic csr_write(input logic [4:0] v);
        CsrWrEn = 1'b1; CsrWrData = v;
        tick();
        CsrWrEn = 1'b0; CsrWrData = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12;
        checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL reset_resvalid got=%b exp=0", ResValid); end
        checks++; if (ResFlags !== 5'b0) begin errors++; $display("FAIL reset_resflags got=%b exp=00000", ResFlags); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (IssueReady !== 1'b1 || StageEn !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b/%b exp=1/1", IssueReady, StageEn); end
        checks++; if (FFlags !== 5'b0) begin errors++; $display("FAIL reset_fflags got=%b exp=00000", FFlags); end
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        IssueValid = 1'b1; IssueTag = 5'h03;
        tick();
        IssueValid = 1'b0; #1;
        checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL single_c1_resvalid got=%b exp=0", ResValid); end
        tick(); #1;
        checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL single_c2_resvalid got=%b exp=0", ResValid); end
        tick();
        FmaInexact = 1'b1; #1;
        checks++; if (ResValid !== 1'b1 || ResTag !== 5'h03) begin errors++; $display("FAIL single_c3_result got=%b/%h exp=1/03", ResValid, ResTag); end
        checks++; if (ResFlags !== 5'b00001) begin errors++; $display("FAIL single_resflags got=%b exp=00001", ResFlags); end
        tick();
        FmaInexact = 1'b0; #1;
        checks++; if (FFlags !== 5'b00001) begin errors++; $display("FAIL single_fflags got=%b exp=00001", FFlags); end
        checks++; if (ResValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL single_drain got=%b/%b exp=0/0", ResValid, Busy); end
        csr_write(5'b0);
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] exp_tags [3];
        exp_tags[0] = 5'd1; exp_tags[1] = 5'd2; exp_tags[2] = 5'd3;
        for (int i = 0; i < 3; i++) begin
            IssueValid = 1'b1; IssueTag = exp_tags[i];
            tick();
        end
        IssueValid = 1'b0; ResReady = 1'b0; FmaOverflow = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (IssueReady !== 1'b0 || StageEn !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d_ready got=%b/%b exp=0/0", c, IssueReady, StageEn); end
            checks++; if (ResValid !== 1'b1 || ResTag !== 5'd1) begin errors++; $display("FAIL b2b_stall%0d_hold got=%b/%0d exp=1/1", c, ResValid, ResTag); end
            checks++; if (ResFlags !== 5'b00100) begin errors++; $display("FAIL b2b_stall%0d_flags got=%b exp=00100", c, ResFlags); end
            tick();
        end
        ResReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ResValid !== 1'b1 || ResTag !== exp_tags[i]) begin errors++; $display("FAIL b2b_drain%0d got=%b/%0d exp=1/%0d", i, ResValid, ResTag, exp_tags[i]); end
            tick();
        end
        FmaOverflow = 1'b0; #1;
        checks++; if (ResValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b/%b exp=0/0", ResValid, Busy); end
        checks++; if (FFlags !== 5'b00100) begin errors++; $display("FAIL b2b_fflags got=%b exp=00100", FFlags); end
    endtask

    task automatic test_csr_same_cycle();
        IssueValid = 1'b1; IssueTag = 5'd7;
        tick();
        IssueValid = 1'b0;
        tick(); tick();
        FmaInvalid = 1'b1; CsrWrEn = 1'b1; CsrWrData = 5'b0;
        tick();
        FmaInvalid = 1'b0; CsrWrEn = 1'b0; #1;
        checks++; if (FFlags !== 5'b10000) begin errors++; $display("FAIL csr_same_cycle got=%b exp=10000", FFlags); end
        csr_write(5'b01010); #1;
        checks++; if (FFlags !== 5'b01010) begin errors++; $display("FAIL csr_write got=%b exp=01010", FFlags); end
        csr_write(5'b00001);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            IssueValid = 1'b1; IssueTag = 5'(4 + i);
            tick();
        end
        IssueTag = 5'd9; FlushE = 1'b1; FmaOverflow = 1'b1; #1;
        checks++; if (ResValid !== 1'b1 || IssueReady !== 1'b1) begin errors++; $display("FAIL flush_cycle got=%b/%b exp=1/1", ResValid, IssueReady); end
        tick();
        IssueValid = 1'b0; FlushE = 1'b0; FmaOverflow = 1'b0; #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", Busy); end
        checks++; if (FFlags !== 5'b00001) begin errors++; $display("FAIL flush_fflags got=%b exp=00001", FFlags); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL flush_after%0d got=%b exp=0", c, ResValid); end
            tick();
        end
        IssueValid = 1'b1; IssueTag = 5'd8;
        tick();
        IssueValid = 1'b0;
        tick(); tick();
        ResReady = 1'b0; FlushE = 1'b1; FmaOverflow = 1'b1;
        tick();
        ResReady = 1'b1; FlushE = 1'b0; FmaOverflow = 1'b0; #1;
        checks++; if (Busy !== 1'b0 || ResValid !== 1'b0) begin errors++; $display("FAIL flush_stalled got=%b/%b exp=0/0", Busy, ResValid); end
        checks++; if (FFlags !== 5'b00001) begin errors++; $display("FAIL flush_stalled_fflags got=%b exp=00001", FFlags); end
    endtask

    task automatic test_async_reset();
        csr_write(5'b11111);
        IssueValid = 1'b1; IssueTag = 5'd1;
        tick();
        IssueTag = 5'd2;
        tick();
        IssueValid = 1'b0;
        reset = 1'b1; #1;
        checks++; if (ResValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL async_reset_pipe got=%b/%b exp=0/0", ResValid, Busy); end
        checks++; if (FFlags !== 5'b0) begin errors++; $display("FAIL async_reset_fflags got=%b exp=00000", FFlags); end
        #1;
        reset = 1'b0;
        IssueValid = 1'b1; IssueTag = 5'h11;
        tick();
        IssueValid = 1'b0;
        tick(); #1;
        checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL post_reset_early got=%b exp=0", ResValid); end
        tick(); #1;
        checks++; if (ResValid !== 1'b1 || ResTag !== 5'h11) begin errors++; $display("FAIL post_reset_result got=%b/%h exp=1/11", ResValid, ResTag); end
        tick();
    endtask

    task automatic test_random();
        logic [TW-1:0] exp_q [$];
        logic [4:0]    model_ff;
        logic [4:0]    exp_rf;
        logic          acc;
        logic [TW-1:0] t;
        csr_write(5'b0);
        model_ff = 5'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            IssueValid   = 1'($urandom_range(0, 1));
            IssueTag     = 5'($urandom_range(0, 31));
            ResReady     = ($urandom_range(0, 9) < 7);
            FlushE       = ($urandom_range(0, 19) == 0);
            CsrWrEn      = ($urandom_range(0, 29) == 0);
            CsrWrData    = 5'($urandom_range(0, 31));
            FmaInvalid   = 1'($urandom_range(0, 1));
            FmaOverflow  = 1'($urandom_range(0, 1));
            FmaUnderflow = 1'($urandom_range(0, 1));
            FmaInexact   = 1'($urandom_range(0, 1));
            #1;
            exp_rf = ResValid ? {FmaInvalid, 1'b0, FmaOverflow, FmaUnderflow, FmaInexact} : 5'b0;
            if (ResFlags !== exp_rf) begin errors++; $display("FAIL rnd_resflags cyc=%0d got=%b exp=%b", cyc, ResFlags, exp_rf); end
            if (IssueReady !== ~(ResValid & ~ResReady)) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b", cyc, IssueReady); end
            if (ResValid && exp_q.size() == 0) begin errors++; $display("FAIL rnd_spurious cyc=%0d got=ResValid exp=empty", cyc); end
            checks += 3;
            acc = ResValid & ResReady & ~FlushE;
            if (acc && exp_q.size() != 0) begin
                t = exp_q.pop_front();
                checks++; if (ResTag !== t) begin errors++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", cyc, ResTag, t); end
            end
            model_ff = (CsrWrEn ? CsrWrData : model_ff) | (acc ? exp_rf : 5'b0);
            if (FlushE) exp_q.delete();
            else if (IssueValid && IssueReady) exp_q.push_back(IssueTag);
            tick();
            checks++; if (FFlags !== model_ff) begin errors++; $display("FAIL rnd_fflags cyc=%0d got=%b exp=%b", cyc, FFlags, model_ff); end
            checks++; if (Busy !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%0d", cyc, Busy, exp_q.size()); end
            if (exp_q.size() > LAT) begin errors++; $display("FAIL rnd_occupancy cyc=%0d got=%0d exp<=%0d", cyc, exp_q.size(), LAT); exp_q.delete(); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_csr_same_cycle();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
